// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Single-outstanding APB (AMBA 3) master. A command taken on the cmd_*
// valid/ready stream becomes one APB SETUP + ACCESS transfer. The result
// (read data, slave error, timeout) is returned on the rsp_* valid/ready
// stream. A wait-state timeout aborts transfers whose slave never raises
// PREADY.
//
// Handshake semantics (both streams): a transfer happens on a rising PCLK
// edge where valid and ready are both high. A producer holds valid and its
// payload stable until that edge. cmd_ready_o is high only in IDLE, so a
// new command is never taken while a response is still pending.
//
// Ports
//   PCLK, PRESETn          clock, synchronous active-low reset
//   cmd_valid_i/ready_o    command handshake
//   cmd_write_i            1 = write, 0 = read
//   cmd_addr_i, cmd_wdata_i command address / write data
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes and timeouts)
//   rsp_err_o              PSLVERR seen or timeout
//   rsp_timeout_o          transfer aborted by timeout
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request outputs
//   PRDATA, PREADY, PSLVERR                APB completion inputs
//   dbg_state              current FSM state (0 IDLE,1 SETUP,2 ACCESS,3 RESP)
// ---------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int APB_ADDR_WIDTH = 5,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic [1:0]                dbg_state
);

    // A zero timeout still needs a 1-bit counter to keep the vector legal.
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter value during the ACCESS cycle that, with PREADY low, completes
    // the TIMEOUT_CYCLES-th consecutive wait cycle.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             cmd_accept;
    logic             access_done;
    logic             access_timeout;

    // Registered-output next values, produced by the output process.
    logic psel_d;
    logic penable_d;
    logic cmd_ready_d;
    logic rsp_valid_d;

    assign dbg_state = state;

    // Transfer-ending conditions, only meaningful in ACCESS.
    always_comb begin
        cmd_accept     = (state == S_IDLE) && cmd_valid_i;
        access_done    = (state == S_ACCESS) && PREADY;
        access_timeout = (state == S_ACCESS) && !PREADY && TIMEOUT_EN &&
                         (wait_cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (cmd_valid_i) next_state = S_SETUP;
            S_SETUP:  next_state = S_ACCESS;
            S_ACCESS: if (access_done || access_timeout) next_state = S_RESP;
            S_RESP:   if (rsp_ready_i) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output logic: decode the upcoming state so the flops below present
    // the control outputs in the same cycle as the state they belong to.
    always_comb begin
        psel_d      = (next_state == S_SETUP) || (next_state == S_ACCESS);
        penable_d   = (next_state == S_ACCESS);
        cmd_ready_d = (next_state == S_IDLE);
        rsp_valid_d = (next_state == S_RESP);
    end

    // Output and datapath registers.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            PWRITE        <= 1'b0;
            PADDR         <= '0;
            PWDATA        <= '0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            cmd_ready_o <= cmd_ready_d;
            rsp_valid_o <= rsp_valid_d;

            // Request fields load only on accept, so they stay stable for
            // the whole transfer and keep their last value afterwards.
            if (cmd_accept) begin
                PWRITE <= cmd_write_i;
                PADDR  <= cmd_addr_i;
                PWDATA <= cmd_wdata_i;
            end

            // Wait counter: cleared entering SETUP, saturating in ACCESS.
            if (cmd_accept) begin
                wait_cnt <= '0;
            end else if ((state == S_ACCESS) && !PREADY && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // Response fields change only when a transfer ends, which keeps
            // them stable for the whole RESP period.
            if (access_done) begin
                rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
                rsp_err_o     <= PSLVERR;
                rsp_timeout_o <= 1'b0;
            end else if (access_timeout) begin
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed plus randomized transfers against apb_master_bridge. The expected
// response of every transfer comes from a transfer-level model: given the
// number of PREADY=0 cycles the slave inserts, the bridge either completes
// after waits+1 ACCESS cycles with the slave's data/error, or aborts after
// TIMEOUT_CYCLES cycles with err=1, timeout=1, rdata=0.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          PCLK;
    logic          PRESETn;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_wdata_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Command offered while a response is back-pressured.
    logic [AW-1:0] q_addr;
    logic [DW-1:0] q_wdata;

    apb_master_bridge #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_write_i  (cmd_write_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA),
        .PRDATA       (PRDATA),
        .PREADY       (PREADY),
        .PSLVERR      (PSLVERR),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Everything idle-looking: all outputs 0 apart from cmd_ready_o.
    task automatic check_quiet(input string tag);
        check({tag, "_cmd_ready"}, DW'(cmd_ready_o), 1);
        check({tag, "_psel"},      DW'(PSEL), 0);
        check({tag, "_penable"},   DW'(PENABLE), 0);
        check({tag, "_pwrite"},    DW'(PWRITE), 0);
        check({tag, "_paddr"},     DW'(PADDR), 0);
        check({tag, "_pwdata"},    PWDATA, 0);
        check({tag, "_rsp_valid"}, DW'(rsp_valid_o), 0);
        check({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
        check({tag, "_rsp_err"},   DW'(rsp_err_o), 0);
        check({tag, "_rsp_to"},    DW'(rsp_timeout_o), 0);
    endtask

    // Driver + checker for one complete transfer. Called at a falling edge
    // with the bridge idle (or a queued command already offered).
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int waits,
                            input logic slverr, input logic [DW-1:0] rdata,
                            input int rsp_delay, input logic queue_next);
        int            n_access;
        logic          exp_to;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;

        // Transfer-level reference model.
        if (TO != 0 && waits >= TO) begin
            n_access  = TO;
            exp_to    = 1'b1;
            exp_err   = 1'b1;
            exp_rdata = '0;
        end else begin
            n_access  = waits + 1;
            exp_to    = 1'b0;
            exp_err   = slverr;
            exp_rdata = wr ? '0 : rdata;
        end

        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        check("idle_cmd_ready", DW'(cmd_ready_o), 1);
        tick();

        // SETUP; scramble command inputs to prove the request was latched.
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = AW'($urandom);
        cmd_wdata_i = $urandom;
        PREADY      = 1'($urandom);
        PSLVERR     = 1'($urandom);
        PRDATA      = $urandom;
        check("setup_psel",      DW'(PSEL), 1);
        check("setup_penable",   DW'(PENABLE), 0);
        check("setup_paddr",     DW'(PADDR), DW'(addr));
        check("setup_pwrite",    DW'(PWRITE), DW'(wr));
        check("setup_pwdata",    PWDATA, wdata);
        check("setup_cmd_ready", DW'(cmd_ready_o), 0);

        for (int k = 0; k < n_access; k++) begin
            tick();
            PREADY  = (k == waits);
            PSLVERR = (k == waits) ? slverr : 1'($urandom);
            PRDATA  = (k == waits) ? rdata : $urandom;
            check("access_psel",    DW'(PSEL), 1);
            check("access_penable", DW'(PENABLE), 1);
            check("access_paddr",   DW'(PADDR), DW'(addr));
            check("access_pwrite",  DW'(PWRITE), DW'(wr));
            check("access_pwdata",  PWDATA, wdata);
            check("access_rsp_valid", DW'(rsp_valid_o), 0);
        end
        tick();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;

        for (int d = 0; d <= rsp_delay; d++) begin
            if (queue_next) begin
                cmd_valid_i = 1'b1;
                cmd_write_i = 1'b1;
                cmd_addr_i  = q_addr;
                cmd_wdata_i = q_wdata;
            end
            rsp_ready_i = (d == rsp_delay);
            check("resp_valid",     DW'(rsp_valid_o), 1);
            check("resp_rdata",     rsp_rdata_o, exp_rdata);
            check("resp_err",       DW'(rsp_err_o), DW'(exp_err));
            check("resp_timeout",   DW'(rsp_timeout_o), DW'(exp_to));
            check("resp_psel",      DW'(PSEL), 0);
            check("resp_penable",   DW'(PENABLE), 0);
            check("resp_cmd_ready", DW'(cmd_ready_o), 0);
            tick();
        end
        rsp_ready_i = 1'b0;
        check("post_rsp_valid", DW'(rsp_valid_o), 0);
        check("post_cmd_ready", DW'(cmd_ready_o), 1);
        check("post_psel",      DW'(PSEL), 0);
    endtask

    initial begin
        PRESETn     = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        rsp_ready_i = 1'b0;
        PRDATA      = '0;
        PREADY      = 1'b0;
        PSLVERR     = 1'b0;
        q_addr      = '0;
        q_wdata     = '0;

        // Reset state
        @(negedge PCLK);
        tick();
        check_quiet("reset");
        check("reset_state", DW'(dbg_state), 0);
        PRESETn = 1'b1;
        tick();
        check_quiet("post_reset");

        // Zero-wait write 0x4 <- 0xDEADBEEF; PRDATA garbage must not leak.
        run_xfer(1'b1, 5'h04, 32'hDEADBEEF, 0, 1'b0, 32'hCAFEF00D, 0, 1'b0);
        // Read 0x0 with three wait cycles.
        run_xfer(1'b0, 5'h00, 32'h0, 3, 1'b0, 32'h12345678, 0, 1'b0);
        // Timeout: PREADY never rises.
        run_xfer(1'b0, 5'h14, 32'h0, 100, 1'b0, 32'h55AA55AA, 0, 1'b0);
        // Timeout boundary: PREADY on the 4th ACCESS cycle wins.
        run_xfer(1'b0, 5'h18, 32'h0, TO - 1, 1'b0, 32'h0BADCAFE, 0, 1'b0);
        // Timeout on a write.
        run_xfer(1'b1, 5'h1C, 32'h11223344, TO, 1'b0, 32'h0, 1, 1'b0);
        // Slave error on read 0x10.
        run_xfer(1'b0, 5'h10, 32'h0, 1, 1'b1, 32'h87654321, 0, 1'b0);

        // Backpressure with a queued write 0xC <- 0xA5.
        q_addr  = 5'h0C;
        q_wdata = 32'h000000A5;
        run_xfer(1'b1, 5'h02, $urandom, 0, 1'b0, 32'h0, 5, 1'b1);
        run_xfer(1'b1, q_addr, q_wdata, 0, 1'b0, 32'h0, 0, 1'b0);

        // Reset during ACCESS with PREADY low.
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 5'h08;
        cmd_wdata_i = 32'h0;
        PREADY      = 1'b0;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        check("mid_access_penable", DW'(PENABLE), 1);
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        check_quiet("mid_reset");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_reset_no_rsp", DW'(rsp_valid_o), 0);
            check("mid_reset_no_psel", DW'(PSEL), 0);
        end
        run_xfer(1'b1, 5'h08, 32'h0000BEEF, 0, 1'b0, 32'h0, 0, 1'b0);

        // Randomized transfers.
        for (int i = 0; i < 40; i++) begin
            run_xfer(1'($urandom), AW'($urandom), $urandom,
                     $urandom_range(0, TO + 2), 1'($urandom), $urandom,
                     $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
